// File: rtl/pipe_pkg.sv
// Shared definitions for the MiniMicro pipeline: instruction field ranges,
// instruction classes and register read/write decode helpers.
package pipe_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_W   = 3;

  // Field ranges of a 16-bit instruction word
  localparam int unsigned OP_HI   = 15;
  localparam int unsigned OP_LO   = 9;
  localparam int unsigned ASEL_HI = 8;
  localparam int unsigned ASEL_LO = 6;
  localparam int unsigned BSEL_HI = 5;
  localparam int unsigned BSEL_LO = 3;
  localparam int unsigned CSEL_HI = 2;
  localparam int unsigned CSEL_LO = 0;
  localparam int unsigned LIT_HI  = 14;
  localparam int unsigned LIT_LO  = 0;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  // Class markers: LIT has bit 15 set, NOWB has bits[15:14] = 01
  localparam int unsigned LIT_BIT  = 15;
  localparam logic [1:0]  NOWB_TAG = 2'b01;

  localparam logic [REG_W-1:0] R0 = 3'd0;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [REG_W-1:0]   reg_sel_t;

  function automatic logic [OP_HI-OP_LO:0] opcode(input instr_t w);
    return w[OP_HI:OP_LO];
  endfunction

  function automatic logic [LIT_HI-LIT_LO:0] literal(input instr_t w);
    return w[LIT_HI:LIT_LO];
  endfunction

  function automatic reg_sel_t asel(input instr_t w);
    return w[ASEL_HI:ASEL_LO];
  endfunction

  function automatic reg_sel_t bsel(input instr_t w);
    return w[BSEL_HI:BSEL_LO];
  endfunction

  function automatic reg_sel_t csel(input instr_t w);
    return w[CSEL_HI:CSEL_LO];
  endfunction

  function automatic logic is_nop(input instr_t w);
    return w == NOP_WORD;
  endfunction

  function automatic logic is_lit(input instr_t w);
    return w[LIT_BIT];
  endfunction

  function automatic logic is_nowb(input instr_t w);
    return w[15:14] == NOWB_TAG;
  endfunction

  // NOWB and ALU read aSel/bSel; NOP and LIT read nothing
  function automatic logic reads_regs(input instr_t w);
    return !is_nop(w) && !is_lit(w);
  endfunction

  // LIT and ALU write a register; NOP and NOWB do not
  function automatic logic writes_reg(input instr_t w);
    return !is_nop(w) && !is_nowb(w);
  endfunction

  function automatic reg_sel_t dest(input instr_t w);
    return is_lit(w) ? R0 : csel(w);
  endfunction

endpackage

// File: rtl/pipe_haz_det.sv
// Read-after-write hazard detector between the stage-2 reader and the
// stage-3/4 producers. Purely combinational.
//   os2, os3, os4        : stage instruction words
//   haz_a3/haz_b3        : operand A/B of os2 depends on os3
//   haz_a4/haz_b4        : operand A/B of os2 depends on os4
module pipe_haz_det
  import pipe_pkg::*;
(
  input  logic [15:0] os2,
  input  logic [15:0] os3,
  input  logic [15:0] os4,
  output logic        haz_a3,
  output logic        haz_b3,
  output logic        haz_a4,
  output logic        haz_b4
);

  logic rd2;
  logic wr3;
  logic wr4;

  assign rd2 = reads_regs(os2);
  assign wr3 = writes_reg(os3);
  assign wr4 = writes_reg(os4);

  assign haz_a3 = rd2 && wr3 && (asel(os2) == dest(os3));
  assign haz_b3 = rd2 && wr3 && (bsel(os2) == dest(os3));
  assign haz_a4 = rd2 && wr4 && (asel(os2) == dest(os4));
  assign haz_b4 = rd2 && wr4 && (bsel(os2) == dest(os4));

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Issue/interlock controller for the five-stage MiniMicro pipeline.
// Owns stage registers os1..os5, accepts fetch via valid/ready, stalls
// stages 1-2 on RAW hazards, and handles branch flush and external hold.
// Build option: define PIPE_FWD_EN to enable stage-4 -> stage-2 forwarding.
//   clk, rst_n           : clock, async active-low reset
//   hold                 : freeze entire pipeline
//   flush                : kill stages 1-3 contents (os1..os3 <- NOP)
//   in_valid, in_instr   : fetch request
//   in_ready             : fetch accepted when in_valid & in_ready (comb)
//   os1..os5             : registered stage instruction words
//   stall                : hazard stall this cycle (comb)
//   fwd_a, fwd_b         : stage-2 operand takes stage-4 result (comb)
//   stall_cnt            : saturating count of stall cycles
module pipe_hazard_ctl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  output logic [15:0]      os1,
  output logic [15:0]      os2,
  output logic [15:0]      os3,
  output logic [15:0]      os4,
  output logic [15:0]      os5,
  output logic             stall,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  logic haz_a3;
  logic haz_b3;
  logic haz_a4;
  logic haz_b4;
  logic stall_raw;

  pipe_haz_det u_haz_det (
    .os2    (os2),
    .os3    (os3),
    .os4    (os4),
    .haz_a3 (haz_a3),
    .haz_b3 (haz_b3),
    .haz_a4 (haz_a4),
    .haz_b4 (haz_b4)
  );

`ifdef PIPE_FWD_EN
  // Stage-4 results are forwarded, so only stage-3 producers interlock
  assign stall_raw = haz_a3 | haz_b3;
  assign fwd_a     = haz_a4 & ~haz_a3 & ~hold;
  assign fwd_b     = haz_b4 & ~haz_b3 & ~hold;
`else
  assign stall_raw = haz_a3 | haz_b3 | haz_a4 | haz_b4;
  assign fwd_a     = 1'b0;
  assign fwd_b     = 1'b0;
`endif

  // hold and flush both override the interlock
  assign stall    = stall_raw & ~hold & ~flush;
  assign in_ready = ~hold & ~flush & ~stall;

  // Stage registers: hold > flush > stall > normal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os1 <= NOP_WORD;
      os2 <= NOP_WORD;
      os3 <= NOP_WORD;
      os4 <= NOP_WORD;
      os5 <= NOP_WORD;
    end else if (hold) begin
      os1 <= os1;
    end else if (flush) begin
      os5 <= os4;
      os4 <= os3;
      os3 <= NOP_WORD;
      os2 <= NOP_WORD;
      os1 <= NOP_WORD;
    end else if (stall) begin
      os5 <= os4;
      os4 <= os3;
      os3 <= NOP_WORD;
    end else begin
      os5 <= os4;
      os4 <= os3;
      os3 <= os2;
      os2 <= os1;
      os1 <= in_valid ? in_instr : NOP_WORD;
    end
  end

  // Saturating stall-cycle counter; stall is already masked by hold/flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
